// File: rtl/decode_pkg.sv
// decode_pkg: shared constants and types for the MIPS decode stage.
//   - opcode constants (6-bit MIPS primary opcodes)
//   - aluop_t: ALU operation class handed to execute
//   - ext_t:   immediate extension mode
//   - ctrl_t:  control bundle produced by decode_ctrl
package decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10,
        ALU_LOGIC = 2'b11
    } aluop_t;

    typedef enum logic [1:0] {
        EXT_SIGN = 2'b00,
        EXT_ZERO = 2'b01,
        EXT_LUI  = 2'b10
    } ext_t;

    // regdst selects rd (1) or rt (0) as destination; reads_rt marks
    // instructions whose rt field is a source operand (hazard detection).
    typedef struct packed {
        logic   regwrite;
        logic   memread;
        logic   memwrite;
        logic   memtoreg;
        logic   branch;
        logic   nbranch;
        logic   alusrc;
        logic   regdst;
        logic   reads_rt;
        logic   halt;
        aluop_t aluop;
        ext_t   ext;
    } ctrl_t;

endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: IF/ID input bundle and ID/EX output bundle of the
// decode stage.
//   slave  : decode stage side (consumes IF/ID, drives ID/EX)
//   master : surrounding pipeline side (drives IF/ID, consumes ID/EX)
// Handshake: i_valid qualifies i_instruction/i_pc4 on every i_step edge;
// o_valid qualifies the ID/EX bundle. There is no ready; back-pressure
// toward fetch is the separate o_stall port of the stage.
interface decode_stage_if #(
    parameter int NB   = 32,
    parameter int REGS = 5
);
    logic [NB-1:0]   i_instruction;
    logic [NB-1:0]   i_pc4;
    logic            i_valid;
    logic            i_flush;

    logic            o_valid;
    logic            o_regwrite;
    logic            o_memread;
    logic            o_memwrite;
    logic            o_memtoreg;
    logic            o_branch;
    logic            o_nbranch;
    logic            o_ALUSrc;
    logic [1:0]      o_ALUop;
    logic [NB-1:0]   o_data_rs;
    logic [NB-1:0]   o_data_rt;
    logic [NB-1:0]   o_extensionresult;
    logic [NB-1:0]   o_pc4;
    logic [REGS-1:0] o_dir_rs;
    logic [REGS-1:0] o_dir_rt;
    logic [REGS-1:0] o_dir_rd;

    modport slave (
        input  i_instruction, i_pc4, i_valid, i_flush,
        output o_valid, o_regwrite, o_memread, o_memwrite, o_memtoreg,
               o_branch, o_nbranch, o_ALUSrc, o_ALUop,
               o_data_rs, o_data_rt, o_extensionresult, o_pc4,
               o_dir_rs, o_dir_rt, o_dir_rd
    );

    modport master (
        output i_instruction, i_pc4, i_valid, i_flush,
        input  o_valid, o_regwrite, o_memread, o_memwrite, o_memtoreg,
               o_branch, o_nbranch, o_ALUSrc, o_ALUop,
               o_data_rs, o_data_rt, o_extensionresult, o_pc4,
               o_dir_rs, o_dir_rt, o_dir_rd
    );

endinterface

// File: rtl/decode_ctrl.sv
// decode_ctrl: combinational opcode -> control bundle and extension mode.
//   opcode : instruction opcode field
//   ctrl   : control bundle; unlisted opcodes decode to an all-zero NOP
module decode_ctrl
    import decode_pkg::*;
#(
    parameter int CTRLNB = 6
) (
    input  logic [CTRLNB-1:0] opcode,
    output ctrl_t             ctrl
);

    always_comb begin
        ctrl       = '0;
        ctrl.aluop = ALU_ADD;
        ctrl.ext   = EXT_SIGN;
        case (opcode)
            CTRLNB'(OP_RTYPE): begin
                ctrl.aluop    = ALU_FUNCT;
                ctrl.regdst   = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.reads_rt = 1'b1;
            end
            CTRLNB'(OP_ADDI): begin
                ctrl.alusrc   = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            CTRLNB'(OP_ANDI), CTRLNB'(OP_ORI): begin
                ctrl.alusrc   = 1'b1;
                ctrl.ext      = EXT_ZERO;
                ctrl.aluop    = ALU_LOGIC;
                ctrl.regwrite = 1'b1;
            end
            CTRLNB'(OP_LUI): begin
                ctrl.alusrc   = 1'b1;
                ctrl.ext      = EXT_LUI;
                ctrl.regwrite = 1'b1;
            end
            CTRLNB'(OP_LW): begin
                ctrl.alusrc   = 1'b1;
                ctrl.memread  = 1'b1;
                ctrl.memtoreg = 1'b1;
                ctrl.regwrite = 1'b1;
            end
            CTRLNB'(OP_SW): begin
                ctrl.alusrc   = 1'b1;
                ctrl.memwrite = 1'b1;
                ctrl.reads_rt = 1'b1;
            end
            CTRLNB'(OP_BEQ): begin
                ctrl.branch   = 1'b1;
                ctrl.aluop    = ALU_SUB;
                ctrl.reads_rt = 1'b1;
            end
            CTRLNB'(OP_BNE): begin
                ctrl.nbranch  = 1'b1;
                ctrl.aluop    = ALU_SUB;
                ctrl.reads_rt = 1'b1;
            end
            CTRLNB'(OP_HALT): begin
                ctrl.halt     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: MIPS instruction decode with integrated ID/EX register.
//   i_clk, i_reset      : clock, synchronous active-high reset
//   i_step              : advance enable; nothing but reset changes state when low
//   bus (slave)         : IF/ID inputs and ID/EX outputs
//   i_wb_*              : writeback port into the register file
//   i_select_reg_dir    : debug read address -> o_data_tx_debug (combinational)
//   o_stall             : load-use stall toward fetch (combinational)
//   o_halt              : sticky halt flag, cleared only by reset
module decode_stage
    import decode_pkg::*;
#(
    parameter int NB     = 32,
    parameter int REGS   = 5,
    parameter int INBITS = 16,
    parameter int CTRLNB = 6
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_step,
    decode_stage_if.slave   bus,
    input  logic            i_wb_regwrite,
    input  logic [REGS-1:0] i_wb_dir_rd,
    input  logic [NB-1:0]   i_wb_data,
    input  logic [REGS-1:0] i_select_reg_dir,
    output logic            o_stall,
    output logic [NB-1:0]   o_data_tx_debug,
    output logic            o_halt
);

    typedef struct packed {
        logic            valid;
        logic            regwrite;
        logic            memread;
        logic            memwrite;
        logic            memtoreg;
        logic            branch;
        logic            nbranch;
        logic            alusrc;
        aluop_t          aluop;
        logic [NB-1:0]   data_rs;
        logic [NB-1:0]   data_rt;
        logic [NB-1:0]   ext;
        logic [NB-1:0]   pc4;
        logic [REGS-1:0] dir_rs;
        logic [REGS-1:0] dir_rt;
        logic [REGS-1:0] dir_rd;
    } idex_t;

    idex_t idex_q, idex_d;
    logic  halt_q, halt_d;
    ctrl_t ctrl;

    logic [CTRLNB-1:0] opcode;
    logic [REGS-1:0]   rs, rt, rd;
    logic [INBITS-1:0] imm;
    logic [NB-1:0]     ext_val, data_rs, data_rt;
    logic              wb_fire, hazard, bubble;

    assign opcode = bus.i_instruction[NB-1 -: CTRLNB];
    assign rs     = bus.i_instruction[NB-CTRLNB-1 -: REGS];
    assign rt     = bus.i_instruction[NB-CTRLNB-REGS-1 -: REGS];
    assign rd     = bus.i_instruction[NB-CTRLNB-2*REGS-1 -: REGS];
    assign imm    = bus.i_instruction[INBITS-1:0];

    decode_ctrl #(.CTRLNB(CTRLNB)) u_ctrl (
        .opcode (opcode),
        .ctrl   (ctrl)
    );

    // Register file. Entry 0 is never written so it always holds zero.
    logic [NB-1:0] rf [2**REGS];

    assign wb_fire = i_step && i_wb_regwrite && (i_wb_dir_rd != '0);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < 2**REGS; i++) rf[i] <= '0;
        end else if (wb_fire) begin
            rf[i_wb_dir_rd] <= i_wb_data;
        end
    end

    // Write-through reads: a write landing this edge is visible now.
    assign data_rs = (wb_fire && i_wb_dir_rd == rs) ? i_wb_data : rf[rs];
    assign data_rt = (wb_fire && i_wb_dir_rd == rt) ? i_wb_data : rf[rt];
    assign o_data_tx_debug = (wb_fire && i_wb_dir_rd == i_select_reg_dir)
                             ? i_wb_data : rf[i_select_reg_dir];

    always_comb begin
        case (ctrl.ext)
            EXT_ZERO: ext_val = {{(NB-INBITS){1'b0}}, imm};
            EXT_LUI:  ext_val = {imm, {(NB-INBITS){1'b0}}};
            default:  ext_val = {{(NB-INBITS){imm[INBITS-1]}}, imm};
        endcase
    end

    // Load-use: the load now in ID/EX writes a register this instruction
    // needs. One bubble clears it because the bubble has memread = 0.
    assign hazard = bus.i_valid && idex_q.valid && idex_q.memread &&
                    (idex_q.dir_rt != '0) &&
                    ((idex_q.dir_rt == rs) || ((idex_q.dir_rt == rt) && ctrl.reads_rt));

    assign bubble  = halt_q || bus.i_flush || hazard;
    assign o_stall = !halt_q && !bus.i_flush && hazard;

    always_comb begin
        idex_d = '0;
        halt_d = halt_q;
        if (!bubble) begin
            idex_d.valid    = bus.i_valid;
            idex_d.regwrite = ctrl.regwrite;
            idex_d.memread  = ctrl.memread;
            idex_d.memwrite = ctrl.memwrite;
            idex_d.memtoreg = ctrl.memtoreg;
            idex_d.branch   = ctrl.branch;
            idex_d.nbranch  = ctrl.nbranch;
            idex_d.alusrc   = ctrl.alusrc;
            idex_d.aluop    = ctrl.aluop;
            idex_d.data_rs  = data_rs;
            idex_d.data_rt  = data_rt;
            idex_d.ext      = ext_val;
            idex_d.pc4      = bus.i_pc4;
            idex_d.dir_rs   = rs;
            idex_d.dir_rt   = rt;
            idex_d.dir_rd   = ctrl.regdst ? rd : rt;
            if (bus.i_valid && ctrl.halt) halt_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            idex_q <= '0;
            halt_q <= 1'b0;
        end else if (i_step) begin
            idex_q <= idex_d;
            halt_q <= halt_d;
        end
    end

    assign o_halt                = halt_q;
    assign bus.o_valid           = idex_q.valid;
    assign bus.o_regwrite        = idex_q.regwrite;
    assign bus.o_memread         = idex_q.memread;
    assign bus.o_memwrite        = idex_q.memwrite;
    assign bus.o_memtoreg        = idex_q.memtoreg;
    assign bus.o_branch          = idex_q.branch;
    assign bus.o_nbranch         = idex_q.nbranch;
    assign bus.o_ALUSrc          = idex_q.alusrc;
    assign bus.o_ALUop           = idex_q.aluop;
    assign bus.o_data_rs         = idex_q.data_rs;
    assign bus.o_data_rt         = idex_q.data_rt;
    assign bus.o_extensionresult = idex_q.ext;
    assign bus.o_pc4             = idex_q.pc4;
    assign bus.o_dir_rs          = idex_q.dir_rs;
    assign bus.o_dir_rt          = idex_q.dir_rt;
    assign bus.o_dir_rd          = idex_q.dir_rd;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and randomized checks of decode_stage against a
// behavioural model of the decode rules, register file and ID/EX register.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        step = 1'b0;
    logic        wb_we = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic [4:0]  sel = '0;
    logic        stall;
    logic [31:0] dbg;
    logic        halt;

    int total = 0;
    int bad   = 0;

    decode_stage_if #(.NB(32), .REGS(5)) bus ();

    decode_stage #(.NB(32), .REGS(5), .INBITS(16), .CTRLNB(6)) dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_step           (step),
        .bus              (bus),
        .i_wb_regwrite    (wb_we),
        .i_wb_dir_rd      (wb_addr),
        .i_wb_data        (wb_data),
        .i_select_reg_dir (sel),
        .o_stall          (stall),
        .o_data_tx_debug  (dbg),
        .o_halt           (halt)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- instruction builders ----------------
    localparam logic [31:0] NOP = 32'h4000_0000;  // opcode 010000: not decoded

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s,
                                          input logic [4:0] t, input logic [15:0] im);
        return {op, s, t, im};
    endfunction

    function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t,
                                          input logic [4:0] d);
        return {6'b000000, s, t, d, 5'd0, 6'h20};
    endfunction

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        valid, regwrite, memread, memwrite, memtoreg, branch, nbranch, alusrc;
        logic [1:0]  aluop;
        logic [31:0] rs_d, rt_d, ext, pc4;
        logic [4:0]  drs, drt, drd;
        logic        rd_known, ext_known;
    } model_t;

    model_t      m;
    logic [31:0] m_rf [32];
    logic        m_halt;

    function automatic logic [31:0] m_read(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (step && wb_we && wb_addr == a) return wb_data;
        return m_rf[a];
    endfunction

    function automatic logic m_hazard();
        logic [31:0] ins;
        logic        uses_rt;
        ins = bus.i_instruction;
        uses_rt = (ins[31:26] == 6'd0) || (ins[31:26] == 6'b101011) ||
                  (ins[31:26] == 6'b000100) || (ins[31:26] == 6'b000101);
        return bus.i_valid && m.valid && m.memread && (m.drt != 5'd0) &&
               ((m.drt == ins[25:21]) || (uses_rt && m.drt == ins[20:16]));
    endfunction

    task automatic model_next();
        model_t      n;
        logic [31:0] ins;
        logic [31:0] sx, zx, lx;
        logic        set_halt;
        n = '0;
        set_halt = 1'b0;
        if (rst) begin
            for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
            m = n;
            m_halt = 1'b0;
            return;
        end
        if (!step) return;
        if (m_halt || bus.i_flush || m_hazard()) begin
            n.rd_known = 1'b1;
            n.ext_known = 1'b1;
        end else begin
            ins = bus.i_instruction;
            sx = 32'($signed(ins[15:0]));
            zx = 32'(ins[15:0]);
            lx = 32'(ins[15:0]) << 16;
            n.valid = bus.i_valid;
            n.pc4   = bus.i_pc4;
            n.drs   = ins[25:21];
            n.drt   = ins[20:16];
            n.rs_d  = m_read(ins[25:21]);
            n.rt_d  = m_read(ins[20:16]);
            case (ins[31:26])
                6'b000000: begin n.aluop = 2'd2; n.regwrite = 1; n.drd = ins[15:11]; n.rd_known = 1; end
                6'b001000: begin n.alusrc = 1; n.ext = sx; n.ext_known = 1; n.regwrite = 1; n.drd = ins[20:16]; n.rd_known = 1; end
                6'b001100, 6'b001101: begin n.alusrc = 1; n.ext = zx; n.ext_known = 1; n.aluop = 2'd3; n.regwrite = 1; n.drd = ins[20:16]; n.rd_known = 1; end
                6'b001111: begin n.alusrc = 1; n.ext = lx; n.ext_known = 1; n.regwrite = 1; n.drd = ins[20:16]; n.rd_known = 1; end
                6'b100011: begin n.alusrc = 1; n.ext = sx; n.ext_known = 1; n.memread = 1; n.memtoreg = 1; n.regwrite = 1; n.drd = ins[20:16]; n.rd_known = 1; end
                6'b101011: begin n.alusrc = 1; n.ext = sx; n.ext_known = 1; n.memwrite = 1; end
                6'b000100: begin n.branch = 1; n.aluop = 2'd1; n.ext = sx; n.ext_known = 1; end
                6'b000101: begin n.nbranch = 1; n.aluop = 2'd1; n.ext = sx; n.ext_known = 1; end
                6'b111111: set_halt = bus.i_valid;
                default: ;
            endcase
        end
        m = n;
        if (wb_we && wb_addr != 5'd0) m_rf[wb_addr] = wb_data;
        if (set_halt) m_halt = 1'b1;
    endtask

    // ---------------- drivers ----------------
    task automatic drive(input logic [31:0] ins, input logic v, input logic fl, input logic st,
                         input logic we, input logic [4:0] wa, input logic [31:0] wd);
        @(negedge clk);
        bus.i_instruction = ins;
        bus.i_pc4         = $urandom;
        bus.i_valid       = v;
        bus.i_flush       = fl;
        step              = st;
        wb_we             = we;
        wb_addr           = wa;
        wb_data           = wd;
        #1;
    endtask

    task automatic tick();
        model_next();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(NOP, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        drive(NOP, 1'b0, 1'b0, 1'b1, 1'b1, 5'd5, 32'h0000_00AA);
        tick();
        sel = 5'd5; #1;
        total++; if (dbg !== 32'hAA) begin bad++; $display("FAIL rf_write: got %h want %h", dbg, 32'hAA); end
        drive(itype(6'b001000, 5'd0, 5'd1, 16'h0001), 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
        tick();
        rst = 1'b1;
        drive(NOP, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        rst = 1'b0;
        total++; if (dbg !== 32'd0) begin bad++; $display("FAIL reset_rf: got %h want 0", dbg); end
        total++; if (bus.o_valid !== 1'b0 || bus.o_regwrite !== 1'b0 || bus.o_ALUSrc !== 1'b0)
            begin bad++; $display("FAIL reset_ctrl: got v=%b rw=%b src=%b want 0", bus.o_valid, bus.o_regwrite, bus.o_ALUSrc); end
        total++; if (bus.o_extensionresult !== 32'd0 || bus.o_dir_rd !== 5'd0 || halt !== 1'b0)
            begin bad++; $display("FAIL reset_data: got ext=%h rd=%0d halt=%b want 0", bus.o_extensionresult, bus.o_dir_rd, halt); end
    endtask

    task automatic test_addi();
        do_reset();
        drive(itype(6'b001000, 5'd0, 5'd1, 16'hFFFF), 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
        tick();
        total++; if (bus.o_extensionresult !== 32'hFFFF_FFFF) begin bad++; $display("FAIL addi_ext: got %h want ffffffff", bus.o_extensionresult); end
        total++; if (bus.o_ALUSrc !== 1'b1 || bus.o_regwrite !== 1'b1 || bus.o_valid !== 1'b1)
            begin bad++; $display("FAIL addi_ctrl: got src=%b rw=%b v=%b want 1", bus.o_ALUSrc, bus.o_regwrite, bus.o_valid); end
        total++; if (bus.o_dir_rd !== 5'd1 || bus.o_ALUop !== 2'b00) begin bad++; $display("FAIL addi_rd: got rd=%0d op=%b want 1/00", bus.o_dir_rd, bus.o_ALUop); end
    endtask

    task automatic test_writethrough();
        do_reset();
        drive(rtype(5'd3, 5'd3, 5'd4), 1'b1, 1'b0, 1'b1, 1'b1, 5'd3, 32'h1234);
        sel = 5'd3; #1;
        total++; if (dbg !== 32'h1234) begin bad++; $display("FAIL wt_debug: got %h want 1234", dbg); end
        tick();
        total++; if (bus.o_data_rs !== 32'h1234 || bus.o_data_rt !== 32'h1234)
            begin bad++; $display("FAIL wt_operands: got rs=%h rt=%h want 1234", bus.o_data_rs, bus.o_data_rt); end
        total++; if (bus.o_dir_rd !== 5'd4 || bus.o_ALUop !== 2'b10) begin bad++; $display("FAIL rtype_rd: got rd=%0d op=%b want 4/10", bus.o_dir_rd, bus.o_ALUop); end
        drive(NOP, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0, 32'hDEAD_BEEF);
        sel = 5'd0; #1;
        total++; if (dbg !== 32'd0) begin bad++; $display("FAIL r0_wt: got %h want 0", dbg); end
        tick();
        drive(rtype(5'd0, 5'd3, 5'd8), 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
        tick();
        total++; if (bus.o_data_rs !== 32'd0 || bus.o_data_rt !== 32'h1234)
            begin bad++; $display("FAIL r0_read: got rs=%h rt=%h want 0/1234", bus.o_data_rs, bus.o_data_rt); end
    endtask

    task automatic test_load_use();
        do_reset();
        drive(itype(6'b100011, 5'd1, 5'd2, 16'd0), 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
        tick();
        total++; if (bus.o_memread !== 1'b1 || bus.o_memtoreg !== 1'b1 || bus.o_dir_rd !== 5'd2)
            begin bad++; $display("FAIL lw_ctrl: got mr=%b mtr=%b rd=%0d want 1/1/2", bus.o_memread, bus.o_memtoreg, bus.o_dir_rd); end
        drive(rtype(5'd2, 5'd1, 5'd5), 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL lu_stall: got %b want 1", stall); end
        tick();
        total++; if (bus.o_valid !== 1'b0 || bus.o_memread !== 1'b0) begin bad++; $display("FAIL lu_bubble: got v=%b mr=%b want 0", bus.o_valid, bus.o_memread); end
        drive(rtype(5'd2, 5'd1, 5'd5), 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL lu_release: got %b want 0", stall); end
        tick();
        total++; if (bus.o_valid !== 1'b1 || bus.o_dir_rs !== 5'd2 || bus.o_dir_rd !== 5'd5)
            begin bad++; $display("FAIL lu_after: got v=%b rs=%0d rd=%0d want 1/2/5", bus.o_valid, bus.o_dir_rs, bus.o_dir_rd); end
        drive(itype(6'b100011, 5'd1, 5'd6, 16'd0), 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
        tick();
        drive(itype(6'b001101, 5'd2, 5'd6, 16'd1), 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL ori_rt_nostall: got %b want 0", stall); end
        tick();
        drive(itype(6'b100011, 5'd1, 5'd2, 16'd0), 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
        tick();
        drive(itype(6'b101011, 5'd1, 5'd2, 16'd4), 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL sw_rt_stall: got %b want 1", stall); end
        tick();
    endtask

    task automatic test_flush_hazard();
        do_reset();
        drive(itype(6'b100011, 5'd1, 5'd2, 16'd0), 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
        tick();
        drive(rtype(5'd2, 5'd1, 5'd5), 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'd0);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_stall: got %b want 0", stall); end
        tick();
        total++; if (bus.o_valid !== 1'b0 || bus.o_regwrite !== 1'b0) begin bad++; $display("FAIL flush_bubble: got v=%b rw=%b want 0", bus.o_valid, bus.o_regwrite); end
    endtask

    task automatic test_ext();
        do_reset();
        drive(itype(6'b001101, 5'd0, 5'd7, 16'h8000), 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
        tick();
        total++; if (bus.o_extensionresult !== 32'h0000_8000 || bus.o_ALUop !== 2'b11)
            begin bad++; $display("FAIL ori_ext: got %h op=%b want 00008000/11", bus.o_extensionresult, bus.o_ALUop); end
        drive(itype(6'b001111, 5'd0, 5'd7, 16'h8000), 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
        tick();
        total++; if (bus.o_extensionresult !== 32'h8000_0000) begin bad++; $display("FAIL lui_ext: got %h want 80000000", bus.o_extensionresult); end
        drive(itype(6'b000101, 5'd1, 5'd2, 16'hFFFE), 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
        tick();
        total++; if (bus.o_extensionresult !== 32'hFFFF_FFFE || bus.o_nbranch !== 1'b1 || bus.o_ALUop !== 2'b01)
            begin bad++; $display("FAIL bne: got ext=%h nb=%b op=%b want fffffffe/1/01", bus.o_extensionresult, bus.o_nbranch, bus.o_ALUop); end
    endtask

    task automatic test_halt();
        do_reset();
        drive(32'hFC00_0000, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
        tick();
        total++; if (halt !== 1'b1 || bus.o_valid !== 1'b1 || bus.o_regwrite !== 1'b0)
            begin bad++; $display("FAIL halt_enter: got h=%b v=%b rw=%b want 1/1/0", halt, bus.o_valid, bus.o_regwrite); end
        drive(itype(6'b001000, 5'd0, 5'd1, 16'h0005), 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
        tick();
        total++; if (halt !== 1'b1 || bus.o_valid !== 1'b0 || bus.o_ALUSrc !== 1'b0)
            begin bad++; $display("FAIL halt_bubble: got h=%b v=%b src=%b want 1/0/0", halt, bus.o_valid, bus.o_ALUSrc); end
        rst = 1'b1;
        drive(NOP, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
        tick();
        rst = 1'b0;
        total++; if (halt !== 1'b0) begin bad++; $display("FAIL halt_reset: got %b want 0", halt); end
    endtask

    task automatic test_hold();
        do_reset();
        drive(itype(6'b001000, 5'd0, 5'd1, 16'h1234), 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
        tick();
        drive(itype(6'b100011, 5'd1, 5'd2, 16'd0), 1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 32'h55);
        sel = 5'd9; #1;
        total++; if (dbg !== 32'd0) begin bad++; $display("FAIL hold_nowt: got %h want 0", dbg); end
        tick();
        total++; if (bus.o_valid !== 1'b1 || bus.o_memread !== 1'b0 || bus.o_extensionresult !== 32'h1234 || bus.o_dir_rd !== 5'd1)
            begin bad++; $display("FAIL hold_idex: got v=%b mr=%b ext=%h rd=%0d want 1/0/1234/1", bus.o_valid, bus.o_memread, bus.o_extensionresult, bus.o_dir_rd); end
        total++; if (dbg !== 32'd0) begin bad++; $display("FAIL hold_rf: got %h want 0", dbg); end
    endtask

    task automatic test_random();
        logic [5:0]  op;
        logic [4:0]  s, t, d;
        logic [31:0] ins;
        do_reset();
        for (int it = 0; it < 400; it++) begin
            case ($urandom_range(0, 11))
                0: op = 6'b000000;  1: op = 6'b001000;  2: op = 6'b001100;
                3: op = 6'b001101;  4: op = 6'b001111;  5, 6: op = 6'b100011;
                7: op = 6'b101011;  8: op = 6'b000100;  9: op = 6'b000101;
                10: op = 6'b100000; default: op = 6'b000010;
            endcase
            s = 5'($urandom_range(0, 7));
            t = 5'($urandom_range(0, 7));
            d = 5'($urandom_range(0, 7));
            ins = (op == 6'd0) ? rtype(s, t, d) : itype(op, s, t, 16'($urandom));
            drive(ins, $urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0, $urandom_range(0, 7) != 0,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
            sel = 5'($urandom_range(0, 7)); #1;
            total++; if (stall !== m_hazard() && !m_halt && !bus.i_flush || stall !== (!m_halt && !bus.i_flush && m_hazard()))
                begin bad++; $display("FAIL rnd_stall it=%0d: got %b want %b", it, stall, !m_halt && !bus.i_flush && m_hazard()); end
            total++; if (dbg !== m_read(sel)) begin bad++; $display("FAIL rnd_debug it=%0d: got %h want %h", it, dbg, m_read(sel)); end
            tick();
            total++; if ({bus.o_valid, bus.o_regwrite, bus.o_memread, bus.o_memwrite, bus.o_memtoreg, bus.o_branch, bus.o_nbranch, bus.o_ALUSrc, bus.o_ALUop}
                         !== {m.valid, m.regwrite, m.memread, m.memwrite, m.memtoreg, m.branch, m.nbranch, m.alusrc, m.aluop})
                begin bad++; $display("FAIL rnd_ctrl it=%0d: got v%b rw%b mr%b mw%b mt%b b%b nb%b s%b op%b want v%b rw%b mr%b mw%b mt%b b%b nb%b s%b op%b", it,
                    bus.o_valid, bus.o_regwrite, bus.o_memread, bus.o_memwrite, bus.o_memtoreg, bus.o_branch, bus.o_nbranch, bus.o_ALUSrc, bus.o_ALUop,
                    m.valid, m.regwrite, m.memread, m.memwrite, m.memtoreg, m.branch, m.nbranch, m.alusrc, m.aluop); end
            total++; if ({bus.o_data_rs, bus.o_data_rt, bus.o_pc4, bus.o_dir_rs, bus.o_dir_rt} !== {m.rs_d, m.rt_d, m.pc4, m.drs, m.drt})
                begin bad++; $display("FAIL rnd_data it=%0d: got rs=%h rt=%h pc=%h a=%0d b=%0d want rs=%h rt=%h pc=%h a=%0d b=%0d", it,
                    bus.o_data_rs, bus.o_data_rt, bus.o_pc4, bus.o_dir_rs, bus.o_dir_rt, m.rs_d, m.rt_d, m.pc4, m.drs, m.drt); end
            if (m.ext_known) begin
                total++; if (bus.o_extensionresult !== m.ext) begin bad++; $display("FAIL rnd_ext it=%0d: got %h want %h", it, bus.o_extensionresult, m.ext); end
            end
            if (m.rd_known) begin
                total++; if (bus.o_dir_rd !== m.drd) begin bad++; $display("FAIL rnd_rd it=%0d: got %0d want %0d", it, bus.o_dir_rd, m.drd); end
            end
            total++; if (halt !== m_halt) begin bad++; $display("FAIL rnd_halt it=%0d: got %b want %b", it, halt, m_halt); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        bus.i_instruction = NOP;
        bus.i_pc4         = '0;
        bus.i_valid       = 1'b0;
        bus.i_flush       = 1'b0;
        m                 = '0;
        m_halt            = 1'b0;
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        test_reset();
        test_addi();
        test_writethrough();
        test_load_use();
        test_flush_hazard();
        test_ext();
        test_halt();
        test_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Parametrised MIPS instruction-decode stage with integrated ID/EX pipeline register. Decodes the IF/ID instruction, reads a write-through register file, sign/zero/LUI-extends the immediate, detects load-use hazards and latches operands plus control into ID/EX. It sits between the IF/ID register and the execute stage. It honours debug single-stepping (`i_step`) and a sticky HALT.

## Interface
Parameters:
- `NB`, 32: data/instruction width.
- `REGS`, 5: register address width; the register file has 2^REGS entries.
- `INBITS`, 16: immediate width.
- `CTRLNB`, 6: opcode/funct width.

Ports:
- `i_clk`  in  1  single clock; all state updates on its rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_step`  in  1  advance enable; when low, no state changes except reset.
- `i_instruction`  in  NB  IF/ID instruction.
- `i_pc4`  in  NB  IF/ID PC+4.
- `i_valid`  in  1  IF/ID holds a real instruction.
- `i_flush`  in  1  squash the current ID instruction (taken branch downstream).
- `i_wb_regwrite`  in  1  writeback enable.
- `i_wb_dir_rd`  in  REGS  writeback address.
- `i_wb_data`  in  NB  writeback data.
- `i_select_reg_dir`  in  REGS  debug read address.
- `o_stall`  out  1  hold PC and IF/ID (combinational).
- `o_data_tx_debug`  out  NB  register[i_select_reg_dir] (combinational).
- `o_valid`, `o_regwrite`, `o_memread`, `o_memwrite`, `o_memtoreg`, `o_branch`, `o_nbranch`, `o_ALUSrc`  out  1 each  ID/EX control bits.
- `o_ALUop`  out  2  ID/EX ALU operation class.
- `o_data_rs`, `o_data_rt`, `o_extensionresult`, `o_pc4`  out  NB each  ID/EX operands.
- `o_dir_rs`, `o_dir_rt`, `o_dir_rd`  out  REGS each  ID/EX addresses; `o_dir_rd` is the destination after RegDst selection.
- `o_halt`  out  1  sticky halt flag.

## Operation
- Fields: opcode = instr[NB-1:NB-CTRLNB], rs = [25:21], rt = [20:16], rd = [15:11], imm = [INBITS-1:0].
- Decode. Any opcode not listed below is a NOP with all control bits 0.
  - R-type, opcode 0: ALUop 10, dest rd, regwrite.
  - ADDI, 001000: ALUSrc, sign extend, ALUop 00, dest rt, regwrite.
  - ANDI / ORI, 001100 / 001101: ALUSrc, zero extend, ALUop 11, dest rt, regwrite.
  - LUI, 001111: ALUSrc, result = imm << (NB-INBITS), ALUop 00, dest rt, regwrite.
  - LW, 100011: ALUSrc, sign extend, memread, memtoreg, regwrite, dest rt.
  - SW, 101011: ALUSrc, sign extend, memwrite.
  - BEQ / BNE, 000100 / 000101: branch / nbranch, ALUop 01, sign extend.
  - HALT, 111111: sets `o_halt`.
- Register file:
  - Entry 0 always reads 0, and writes to it are ignored.
  - A write occurs when i_step && i_wb_regwrite.
  - Write-through: a same-cycle read of the address being written returns `i_wb_data`. This applies to the rs, rt and debug ports.
  - Reset clears all entries to 0.
- Load-use hazard: hazard = i_valid && o_valid && o_memread && o_dir_rt≠0 && (o_dir_rt==rs || (o_dir_rt==rt && the instruction reads rt)). R-type, SW, BEQ and BNE read rt.
- Priority per step, highest first:
  1. reset
  2. halted: ID/EX gets a bubble
  3. i_flush: bubble, o_stall=0
  4. hazard: bubble, o_stall=1
  5. normal: latch the decoded instruction; o_valid=i_valid.
- Bubble means o_valid and all control bits are 0; data fields are don't-care but driven 0.
- HALT: the HALT instruction itself enters ID/EX as a NOP with o_valid=1. `o_halt` is set at that step and stays set until reset.

## Timing
- Reset: every ID/EX output and `o_halt` are 0, and the register file is zero.
- Latency: one `i_step` edge from IF/ID to ID/EX outputs.
- With i_step=0, all outputs hold their values.
- `o_stall` and `o_data_tx_debug` are combinational from current inputs and state.
- `o_stall` is forced 0 while halted or flushing.
- A load-use stall lasts exactly one step. After the bubble, o_memread=0, so the hazard clears.
- A reset asserted mid-stall or mid-halt wins and takes effect on that edge.

## Structure
- Package `decode_pkg`:
  - opcode constants;
  - ALUop encodings (00 add, 01 sub/compare, 10 funct, 11 logic-imm);
  - extension-mode encodings (00 sign, 01 zero, 10 lui).
- Sub-module `decode_ctrl`: combinational opcode → control bundle plus extension mode. The register file and ID/EX register stay inline.

## Test plan
- Reset, then i_step=1, instr ADDI $1,$0,0xFFFF, i_valid=1 → next edge: o_extensionresult=0xFFFFFFFF, o_ALUSrc=1, o_dir_rd=1, o_regwrite=1.
- WB writes $3=0x1234 in the same cycle that ID decodes ADD $4,$3,$3 → o_data_rs = o_data_rt = 0x1234 after the edge, and `o_data_tx_debug` for address 3 shows 0x1234 in that cycle.
- LW $2,0($1) followed by ADD $5,$2,$1 → one step with o_stall=1 and a bubble (o_valid=0). Next step: ADD latched with o_dir_rs=2. A following ORI $6,$2,1 after a load does not stall on rt.
- Hazard and i_flush in the same cycle → o_stall=0 and a bubble.
- ORI $7,$0,0x8000 → result 0x00008000. LUI $7,0x8000 → result 0x80000000. A write to $0 reads back 0.
- HALT, then ADDI → o_halt=1 persists and the following ID/EX entries are bubbles. i_step=0 holds all outputs. i_reset clears o_halt.
